mem_bus_arbiter: RTL and testbench

//   Two-requester arbiter for the shared 8-bit memory bus: requester 0 = instruction fetch,

---
 rtl/mem_bus_arbiter_pkg.sv | 37 +++
 rtl/mem_bus_arbiter_if.sv | 29 ++
 rtl/mem_bus_arbiter_bus_mux2.sv | 27 ++
 rtl/mem_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-requester memory bus arbiter: FSM encoding,
// requester indices and small helper functions.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_TURN = 2'd3
  } arb_state_e;

  localparam int REQ_IFETCH = 0;
  localparam int REQ_DATA   = 1;

  // Hold counter must reach MAX_HOLD; a zero limit still needs one bit.
  function automatic int hold_width(input int max_hold);
    int w;
    w = $clog2(max_hold + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  function automatic logic [1:0] gnt_of_state(input arb_state_e s);
    logic [1:0] g;
    case (s)
      ST_GNT0: g = 2'b01;
      ST_GNT1: g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester/bus bundle of the memory bus arbiter. The arbiter uses the slave
// modport; the requesters (or a bench) use the master modport.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [1:0]        req;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              we0;
  logic              we1;
  logic [1:0]        gnt;
  logic              sel;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_we;

  modport master (
    output req, addr0, addr1, wdata0, wdata1, we0, we1,
    input  gnt, sel, bus_addr, bus_wdata, bus_we
  );

  modport slave (
    input  req, addr0, addr1, wdata0, wdata1, we0, we1,
    output gnt, sel, bus_addr, bus_wdata, bus_we
  );
endinterface

// File: rtl/mem_bus_arbiter_bus_mux2.sv
// W-bit 2:1 bus multiplexer whose output is forced to zero while the bus is
// not granted, so nothing from an idle requester leaks downstream.
module bus_mux2 #(
  parameter int W = 8
) (
  input  logic         sel,
  input  logic         en,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  output logic [W-1:0] y
);

  // Gated select
  always_comb begin
    y = {W{1'b0}};
    if (en) begin
      if (sel) begin
        y = a1;
      end else begin
        y = a0;
      end
    end else begin
      y = {W{1'b0}};
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for the shared memory bus with bounded
// hold time and a one-cycle dead turnaround between owners.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_bus_arbiter_if.slave   bus
);

  localparam int HOLD_W = hold_width(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD);
  localparam logic              PREEMPT_EN = (MAX_HOLD != 0);

  arb_state_e        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              sel_q, sel_d;
  logic              last_q, last_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic enter_s;
  logic side_s;
  logic own_s;
  logic own_req_s;
  logic oth_req_s;
  logic preempt_s;

  assign preempt_s = PREEMPT_EN && (hold_cnt_q == HOLD_LIM);

  // Next-state, grant pointer and hold counter
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    hold_cnt_d = hold_cnt_q;
    enter_s    = 1'b0;
    side_s     = last_q;
    own_s      = (state_q == ST_GNT1);
    own_req_s  = bus.req[own_s];
    oth_req_s  = bus.req[~own_s];

    case (state_q)
      ST_IDLE: begin
        if (bus.req[REQ_IFETCH] && bus.req[REQ_DATA]) begin
          enter_s = 1'b1;
          side_s  = ~last_q;
        end else if (bus.req[REQ_IFETCH]) begin
          enter_s = 1'b1;
          side_s  = 1'b0;
        end else if (bus.req[REQ_DATA]) begin
          enter_s = 1'b1;
          side_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (!own_req_s && !oth_req_s) begin
          state_d = ST_IDLE;
        end else if (!own_req_s) begin
          state_d = ST_TURN;
        end else if (oth_req_s && preempt_s) begin
          state_d = ST_TURN;
        end else begin
          state_d = state_q;
          if (hold_cnt_q != HOLD_SAT) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end else begin
            hold_cnt_d = hold_cnt_q;
          end
        end
      end
      ST_TURN: begin
        // The side that did not own the bus last gets first pick.
        if (bus.req[~last_q]) begin
          enter_s = 1'b1;
          side_s  = ~last_q;
        end else if (bus.req[last_q]) begin
          enter_s = 1'b1;
          side_s  = last_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_s) begin
      state_d    = side_s ? ST_GNT1 : ST_GNT0;
      last_d     = side_s;
      sel_d      = side_s;
      hold_cnt_d = {HOLD_W{1'b0}};
    end else begin
      sel_d = sel_q;
    end

    gnt_d = gnt_of_state(state_d);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 2'b00;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;
      hold_cnt_q <= {HOLD_W{1'b0}};
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.gnt = gnt_q;
  assign bus.sel = sel_q;

  bus_mux2 #(.W(ADDR_W)) u_mux_addr (
    .sel (sel_q),
    .en  (|gnt_q),
    .a0  (bus.addr0),
    .a1  (bus.addr1),
    .y   (bus.bus_addr)
  );

  bus_mux2 #(.W(DATA_W)) u_mux_wdata (
    .sel (sel_q),
    .en  (|gnt_q),
    .a0  (bus.wdata0),
    .a1  (bus.wdata1),
    .y   (bus.bus_wdata)
  );

  bus_mux2 #(.W(1)) u_mux_we (
    .sel (sel_q),
    .en  (|gnt_q),
    .a0  (bus.we0),
    .a1  (bus.we1),
    .y   (bus.bus_we)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance with MAX_HOLD=8 and one
// with MAX_HOLD=0 (no preemption), sharing clock and reset.
module tb_mem_bus_arbiter;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  mem_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) if_a ();
  mem_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) if_b ();

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_HOLD(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_HOLD(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_gnt;
    logic       exp_sel;
    pass_cnt  = 0;
    total_cnt = 0;

    rst_n       = 1'b0;
    if_a.req    = 2'b11;
    if_a.addr0  = 8'h11;
    if_a.addr1  = 8'h3C;
    if_a.wdata0 = 8'hA5;
    if_a.wdata1 = 8'h5A;
    if_a.we0    = 1'b1;
    if_a.we1    = 1'b1;
    if_b.req    = 2'b00;
    if_b.addr0  = 8'h22;
    if_b.addr1  = 8'h44;
    if_b.wdata0 = 8'h00;
    if_b.wdata1 = 8'h00;
    if_b.we0    = 1'b0;
    if_b.we1    = 1'b0;

    // Reset with both requesting
    tick();
    tick();
    chk("rst_gnt", 32'(if_a.gnt), 32'h0);
    chk("rst_sel", 32'(if_a.sel), 32'h0);
    chk("rst_we", 32'(if_a.bus_we), 32'h0);
    chk("rst_addr", 32'(if_a.bus_addr), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rel_gnt", 32'(if_a.gnt), 32'h1);
    chk("rel_addr", 32'(if_a.bus_addr), 32'h11);
    chk("rel_wdata", 32'(if_a.bus_wdata), 32'hA5);

    // Both drop -> idle
    if_a.req = 2'b00;
    tick();
    chk("idle_gnt", 32'(if_a.gnt), 32'h0);

    // Single requester 1
    if_a.req = 2'b10;
    tick();
    chk("single_gnt", 32'(if_a.gnt), 32'h2);
    chk("single_sel", 32'(if_a.sel), 32'h1);
    chk("single_addr", 32'(if_a.bus_addr), 32'h3C);
    chk("single_wdata", 32'(if_a.bus_wdata), 32'h5A);
    chk("single_we", 32'(if_a.bus_we), 32'h1);
    if_a.req = 2'b00;
    tick();
    chk("single_drop_gnt", 32'(if_a.gnt), 32'h0);
    chk("single_drop_addr", 32'(if_a.bus_addr), 32'h0);
    chk("single_drop_we", 32'(if_a.bus_we), 32'h0);
    chk("single_drop_sel", 32'(if_a.sel), 32'h1);

    // Contention: 8 x 01, 00, 8 x 10, 00, repeating
    if_a.req = 2'b11;
    for (int i = 0; i < 36; i++) begin
      tick();
      if ((i % 18) < 8) begin
        exp_gnt = 2'b01;
      end else if ((i % 18) == 8) begin
        exp_gnt = 2'b00;
      end else if ((i % 18) < 17) begin
        exp_gnt = 2'b10;
      end else begin
        exp_gnt = 2'b00;
      end
      exp_sel = ((i % 18) >= 9);
      chk($sformatf("rr_gnt[%0d]", i), 32'(if_a.gnt), 32'(exp_gnt));
      chk($sformatf("rr_sel[%0d]", i), 32'(if_a.sel), 32'(exp_sel));
      chk($sformatf("rr_we[%0d]", i), 32'(if_a.bus_we), 32'(|exp_gnt));
    end

    // Release handoff from owner 0 to owner 1
    tick();
    chk("hand_gnt0", 32'(if_a.gnt), 32'h1);
    if_a.req = 2'b10;
    tick();
    chk("hand_turn_gnt", 32'(if_a.gnt), 32'h0);
    chk("hand_turn_we", 32'(if_a.bus_we), 32'h0);
    chk("hand_turn_sel", 32'(if_a.sel), 32'h0);
    tick();
    chk("hand_gnt1", 32'(if_a.gnt), 32'h2);
    chk("hand_we1", 32'(if_a.bus_we), 32'h1);
    chk("hand_addr1", 32'(if_a.bus_addr), 32'h3C);

    // Request dropped in the cycle it is granted
    if_a.req = 2'b00;
    tick();
    chk("pulse_idle", 32'(if_a.gnt), 32'h0);
    if_a.req = 2'b01;
    tick();
    if_a.req = 2'b00;
    chk("pulse_gnt", 32'(if_a.gnt), 32'h1);
    tick();
    chk("pulse_rel", 32'(if_a.gnt), 32'h0);

    // No preemption when MAX_HOLD=0
    if_b.req = 2'b11;
    tick();
    chk("nohold_first", 32'(if_b.gnt), 32'h1);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk($sformatf("nohold_gnt[%0d]", i), 32'(if_b.gnt), 32'h1);
    end
    if_b.req = 2'b10;
    tick();
    chk("nohold_turn", 32'(if_b.gnt), 32'h0);
    tick();
    chk("nohold_gnt1", 32'(if_b.gnt), 32'h2);

    // Asynchronous reset in the middle of a write grant
    if_a.req = 2'b10;
    tick();
    chk("arst_pre_gnt", 32'(if_a.gnt), 32'h2);
    chk("arst_pre_we", 32'(if_a.bus_we), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(if_a.gnt), 32'h0);
    chk("arst_we", 32'(if_a.bus_we), 32'h0);
    chk("arst_sel", 32'(if_a.sel), 32'h0);
    if_a.req = 2'b11;
    #2;
    rst_n = 1'b1;
    tick();
    chk("arst_rel_gnt", 32'(if_a.gnt), 32'h1);
    chk("arst_rel_we", 32'(if_a.bus_we), 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
